an_decoder_seq: RTL

- Parametrised, multi-cycle successor to the combinational AN-code decoder.
- Accepts one AN-coded word A*N that may carry a single unidirectional low-to-high (0->1) bit error.
- Computes the residue mod A, clears the indicated bit, and divides by A to recover N.
- Sits between the AN-protected datapath and consumers, using valid/ready handshakes on both sides.

---
 rtl/an_dec_pkg.sv | 13 +
 rtl/an_syndrome_lut.sv | 21 ++
 rtl/an_decoder_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/an_dec_pkg.sv
// an_dec_pkg: shared state encoding and elaboration-time helpers for the AN decoder
package an_dec_pkg;
  typedef enum logic [2:0] {IDLE, RESID, CORR, DIV, DONE} state_t;
  function automatic int res_w(input int a);
    return $clog2(a);
  endfunction
  function automatic int pow2_mod(input int i, input int a);
    int p;
    p = 1 % a;
    for (int k = 0; k < i; k++) p = (2 * p) % a;
    return p;
  endfunction
endpackage

// File: rtl/an_syndrome_lut.sv
// an_syndrome_lut: maps a nonzero residue to the single 0->1 bit that explains it
import an_dec_pkg::*;
module an_syndrome_lut #(
  parameter int A = 13,
  parameter int AN_W = 12
) (
  input  logic [res_w(A)-1:0] residue,
  input  logic [AN_W-1:0]     data,
  output logic [AN_W-1:0]     err_bit,
  output logic                hit,
  output logic                ambiguous
);
  localparam int RW = res_w(A);
  logic [AN_W-1:0] match;
  for (genvar i = 0; i < AN_W; i++) begin : g_m
    assign match[i] = (residue != '0) && (residue == RW'(pow2_mod(i, A)));
  end
  assign ambiguous = (match & (match - 1'b1)) != '0;
  assign hit = !ambiguous && ((match & data) != '0);
  assign err_bit = hit ? match : '0;
endmodule

// File: rtl/an_decoder_seq.sv
// an_decoder_seq: multi-cycle AN-code decoder with single 0->1 correction; ANDEC_ERR_CNT_EN adds error counters
import an_dec_pkg::*;
module an_decoder_seq #(
  parameter int A = 13,
  parameter int AN_W = 12,
  parameter int N_W = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AN_W-1:0] in_an,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_W-1:0]  out_n,
  output logic            out_corrected,
  output logic            out_uncorr
`ifdef ANDEC_ERR_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
`endif
);
  localparam int RW = res_w(A);
  localparam int CW = $clog2(AN_W + 1);
  localparam logic [RW:0] AV = (RW + 1)'(A);
  localparam logic [CW-1:0] LAST_R = CW'(AN_W - 1);
  localparam logic [CW-1:0] LAST_D = CW'(AN_W);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [AN_W-1:0] an, sh, q, err_bit;
  logic [RW-1:0] r, r_nx;
  logic [RW:0] t;
  logic ge, step, hit, amb, corr, unc;
  an_syndrome_lut #(.A(A), .AN_W(AN_W)) u_lut (
    .residue(r), .data(an), .err_bit(err_bit), .hit(hit), .ambiguous(amb)
  );
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // Residue and restoring division share one shift-and-conditionally-subtract step
  assign t = {r, sh[AN_W-1]};
  assign ge = t >= AV;
  assign r_nx = RW'(ge ? t - AV : t);
  assign step = (state == RESID) || (state == DIV && cnt != LAST_D);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = in_valid ? RESID : IDLE;
      RESID:   nxt = cnt == LAST_R ? CORR : RESID;
      CORR:    nxt = DIV;
      DIV:     nxt = cnt == LAST_D ? DONE : DIV;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // The extra DIV cycle at cnt==AN_W registers the result and range check
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      out_n <= '0;
      out_corrected <= 1'b0;
      out_uncorr <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? '0 : cnt + 1'b1;
      if (state == DIV && cnt == LAST_D) begin
        out_n <= q[N_W-1:0];
        out_corrected <= corr;
        out_uncorr <= unc || (q[AN_W-1:N_W] != '0);
      end else if (state == DONE && out_ready) begin
        out_corrected <= 1'b0;
        out_uncorr <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      an <= in_an;
      sh <= in_an;
      r <= '0;
    end else if (state == CORR) begin
      sh <= an & ~err_bit;
      r <= '0;
      corr <= hit;
      unc <= amb || (r != '0 && !hit);
    end else if (step) begin
      sh <= sh << 1;
      r <= r_nx;
      q <= {q[AN_W-2:0], ge};
    end
  end
`ifdef ANDEC_ERR_CNT_EN
  logic hs;
  assign hs = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_corr <= '0;
      cnt_uncorr <= '0;
    end else begin
      if (hs && out_corrected && !(&cnt_corr)) cnt_corr <= cnt_corr + 1'b1;
      if (hs && out_uncorr && !(&cnt_uncorr)) cnt_uncorr <= cnt_uncorr + 1'b1;
    end
  end
`endif
endmodule
